// File: rtl/vga_timing_if.sv
// Raster timing bundle between vga_timing_gen and the colour generator / connector.
// frameCount exists only when VGA_FRAME_CNT_EN is defined.
interface vga_timing_if;
  logic [10:0] hCount;
  logic [10:0] vCount;
  logic        blank;
  logic        hSync;
  logic        vSync;
  logic        frameEnd;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0]  frameCount;
`endif

  modport master (
    output hCount, vCount, blank, hSync, vSync, frameEnd
`ifdef VGA_FRAME_CNT_EN
    , frameCount
`endif
  );

  modport slave (
    input hCount, vCount, blank, hSync, vSync, frameEnd
`ifdef VGA_FRAME_CNT_EN
    , frameCount
`endif
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (640x480@60 default). Optional macro VGA_FRAME_CNT_EN
// adds an 8-bit frame counter output.
//
// state | meaning
// H_ACT | visible pixels of the line
// H_FP  | horizontal front porch
// H_SYN | horizontal sync pulse
// H_BP  | horizontal back porch
// V_ACT | visible lines of the frame
// V_FP  | vertical front porch
// V_SYN | vertical sync lines
// V_BP  | vertical back porch
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic         clk_25mhz,
  input  logic         reset,
  input  logic         en,
  vga_timing_if.master vga
);

  localparam logic [10:0] H_FP_START  = 11'(H_VISIBLE);
  localparam logic [10:0] H_SYN_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] H_BP_START  = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] H_LAST      = 11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [10:0] V_FP_START  = 11'(V_VISIBLE);
  localparam logic [10:0] V_SYN_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] V_BP_START  = 11'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [10:0] V_LAST      = 11'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

  typedef enum logic [1:0] {H_ACT, H_FP, H_SYN, H_BP} h_state_e;
  typedef enum logic [1:0] {V_ACT, V_FP, V_SYN, V_BP} v_state_e;

  h_state_e    h_state_q, h_state_d;
  v_state_e    v_state_q, v_state_d;
  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic        blank_q, blank_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        frame_end_q, frame_end_d;
  logic        h_wrap;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0]  frame_cnt_q, frame_cnt_d;
`endif

  always_ff @(posedge clk_25mhz or negedge reset) begin
    if (!reset) begin
      h_state_q   <= H_ACT;
      v_state_q   <= V_ACT;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      blank_q     <= 1'b0;
      hsync_q     <= ~SYNC_POL;
      vsync_q     <= ~SYNC_POL;
      frame_end_q <= 1'b0;
`ifdef VGA_FRAME_CNT_EN
      frame_cnt_q <= '0;
`endif
    end else begin
      h_state_q   <= h_state_d;
      v_state_q   <= v_state_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      blank_q     <= blank_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      frame_end_q <= frame_end_d;
`ifdef VGA_FRAME_CNT_EN
      frame_cnt_q <= frame_cnt_d;
`endif
    end
  end

  always_comb begin
    h_state_d   = h_state_q;
    v_state_d   = v_state_q;
    h_cnt_d     = h_cnt_q;
    v_cnt_d     = v_cnt_q;
    blank_d     = blank_q;
    hsync_d     = hsync_q;
    vsync_d     = vsync_q;
    frame_end_d = frame_end_q;
`ifdef VGA_FRAME_CNT_EN
    frame_cnt_d = frame_cnt_q;
`endif
    // >= also catches an out-of-range count and forces it back to 0
    h_wrap      = (h_cnt_q >= H_LAST);

    if (en) begin
      h_cnt_d = h_wrap ? '0 : h_cnt_q + 11'd1;
      if (v_cnt_q > V_LAST) begin
        v_cnt_d = '0;
      end else if (h_wrap) begin
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 11'd1;
      end

      // Boundary compares are on the next count, so the state lines up with the
      // count presented in the same cycle; v_cnt_d only moves on the line wrap.
      case (h_state_q)
        H_ACT:   if (h_cnt_d == H_FP_START)  h_state_d = H_FP;
        H_FP:    if (h_cnt_d == H_SYN_START) h_state_d = H_SYN;
        H_SYN:   if (h_cnt_d == H_BP_START)  h_state_d = H_BP;
        H_BP:    if (h_cnt_d == '0)          h_state_d = H_ACT;
        default: h_state_d = H_ACT;
      endcase
      if (h_cnt_d == '0) h_state_d = H_ACT;

      case (v_state_q)
        V_ACT:   if (v_cnt_d == V_FP_START)  v_state_d = V_FP;
        V_FP:    if (v_cnt_d == V_SYN_START) v_state_d = V_SYN;
        V_SYN:   if (v_cnt_d == V_BP_START)  v_state_d = V_BP;
        V_BP:    if (v_cnt_d == '0)          v_state_d = V_ACT;
        default: v_state_d = V_ACT;
      endcase
      if (v_cnt_d == '0) v_state_d = V_ACT;

      blank_d     = !((h_state_d == H_ACT) && (v_state_d == V_ACT));
      hsync_d     = (h_state_d == H_SYN) ? SYNC_POL : ~SYNC_POL;
      vsync_d     = (v_state_d == V_SYN) ? SYNC_POL : ~SYNC_POL;
      frame_end_d = (h_cnt_d == H_LAST) && (v_cnt_d == V_LAST);
`ifdef VGA_FRAME_CNT_EN
      if (frame_end_q) frame_cnt_d = frame_cnt_q + 8'd1;
`endif
    end
  end

  assign vga.hCount   = h_cnt_q;
  assign vga.vCount   = v_cnt_q;
  assign vga.blank    = blank_q;
  assign vga.hSync    = hsync_q;
  assign vga.vSync    = vsync_q;
  assign vga.frameEnd = frame_end_q;
`ifdef VGA_FRAME_CNT_EN
  assign vga.frameCount = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full-size instance for horizontal/enable/reset
// checks, a shrunken active-high-sync instance for whole-frame behaviour.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_m, en_m, rst_s, en_s;
  vga_timing_if vm ();
  vga_timing_if vsm ();

  vga_timing_gen u_main (
    .clk_25mhz (clk),
    .reset     (rst_m),
    .en        (en_m),
    .vga       (vm)
  );

  // 8 clocks per line, 6 lines per frame: 48 clocks per frame
  vga_timing_gen #(
    .H_VISIBLE (4), .H_FRONT (1), .H_SYNC (2), .H_BACK (1),
    .V_VISIBLE (3), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
    .SYNC_POL  (1'b1)
  ) u_small (
    .clk_25mhz (clk),
    .reset     (rst_s),
    .en        (en_s),
    .vga       (vsm)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int adv;
    int hc;
    int vc;
    bit b;
    bit hs;
    bit vs;
    bit fe;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [25:0] pk(int hc, int vc, bit b, bit hs, bit vs, bit fe);
    return {11'(hc), 11'(vc), b, hs, vs, fe};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [25:0] act_m();
    return {vm.hCount, vm.vCount, vm.blank, vm.hSync, vm.vSync, vm.frameEnd};
  endfunction

  function automatic logic [25:0] act_s();
    return {vsm.hCount, vsm.vCount, vsm.blank, vsm.hSync, vsm.vSync, vsm.frameEnd};
  endfunction

  int mh, mv, vs_cnt, fe_cnt;
  logic [25:0] exp_s;

  initial begin
    vecs[0] = '{0,     0,   0, 0, 1, 1, 0};
    vecs[1] = '{639,   639, 0, 0, 1, 1, 0};
    vecs[2] = '{1,     640, 0, 1, 1, 1, 0};
    vecs[3] = '{15,    655, 0, 1, 1, 1, 0};
    vecs[4] = '{1,     656, 0, 1, 0, 1, 0};
    vecs[5] = '{95,    751, 0, 1, 0, 1, 0};
    vecs[6] = '{1,     752, 0, 1, 1, 1, 0};
    vecs[7] = '{47,    799, 0, 1, 1, 1, 0};
    vecs[8] = '{1,     0,   1, 0, 1, 1, 0};
    vecs[9] = '{39300, 100, 50, 0, 1, 1, 0};

    rst_m = 1'b0; en_m = 1'b1;
    rst_s = 1'b0; en_s = 1'b1;
    tick(10);
    chk("reset_state", act_m(), pk(0, 0, 0, 1, 1, 0));
    chk("reset_state_small", act_s(), pk(0, 0, 0, 0, 0, 0));
    rst_m = 1'b1;

    // full-size instance: horizontal boundaries, line wrap, run to (100,50)
    for (int i = 0; i < 10; i++) begin
      tick(vecs[i].adv);
      chk($sformatf("vec%0d", i), act_m(),
          pk(vecs[i].hc, vecs[i].vc, vecs[i].b, vecs[i].hs, vecs[i].vs, vecs[i].fe));
    end

    en_m = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("en_freeze", act_m(), pk(100, 50, 0, 1, 1, 0));
    end
    en_m = 1'b1;
    tick(1);
    chk("en_resume", act_m(), pk(101, 50, 0, 1, 1, 0));
    tick(599);
    chk("at_700_50", act_m(), pk(700, 50, 1, 0, 1, 0));

    #2 rst_m = 1'b0;
    #1 chk("async_reset", act_m(), pk(0, 0, 0, 1, 1, 0));
    tick(3);
    chk("reset_hold", act_m(), pk(0, 0, 0, 1, 1, 0));
    rst_m = 1'b1;
    chk("release_state", act_m(), pk(0, 0, 0, 1, 1, 0));
    tick(1);
    chk("first_count", act_m(), pk(1, 0, 0, 1, 1, 0));

    // small instance: three frames against a range-based reference model
    rst_s = 1'b1;
    mh = 0; mv = 0; vs_cnt = 0; fe_cnt = 0;
    for (int c = 0; c < 144; c++) begin
      exp_s = pk(mh, mv, !(mh < 4 && mv < 3), (mh == 5 || mh == 6), (mv == 4),
                 (mh == 7 && mv == 5));
      chk("small_frame", act_s(), exp_s);
      if (vsm.vSync) vs_cnt++;
      if (vsm.frameEnd) fe_cnt++;
      tick(1);
      if (mh == 7) begin
        mh = 0;
        mv = (mv == 5) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
    end
    chk("vsync_cycles", vs_cnt, 24);
    chk("frame_end_pulses", fe_cnt, 3);
    chk("frame_restart", act_s(), pk(0, 0, 0, 0, 0, 0));
`ifdef VGA_FRAME_CNT_EN
    chk("frame_count_3", vsm.frameCount, 3);
`endif

    tick(47);
    chk("frame_end_pos", act_s(), pk(7, 5, 1, 0, 0, 1));
    en_s = 1'b0;
    tick(5);
    chk("frame_end_stretch", act_s(), pk(7, 5, 1, 0, 0, 1));
`ifdef VGA_FRAME_CNT_EN
    chk("frame_count_hold", vsm.frameCount, 3);
`endif
    en_s = 1'b1;
    tick(1);
    chk("frame_end_clear", act_s(), pk(0, 0, 0, 0, 0, 0));
`ifdef VGA_FRAME_CNT_EN
    chk("frame_count_4", vsm.frameCount, 4);

    #2 rst_s = 1'b0;
    #1 chk("frame_count_reset", vsm.frameCount, 0);
    tick(1);
    rst_s = 1'b1;
    tick(257 * 48);
    chk("frame_count_wrap", vsm.frameCount, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
